// File: rtl/matvec_scheduler.sv
// matvec_scheduler
//   Runs a batch of up to NUM_JOBS matrix-vector jobs through one shared
//   matvec engine. For every selected job it:
//     - pulses the engine start;
//     - streams the input vector from vector SRAM in BANDWIDTH-word chunks;
//     - exposes the job index so the matrix loader can pick the weight bank;
//     - saturates each Q20.12 engine result to Q4.12 and writes it to the
//       gate result buffer at {job, row}.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_*             batch request (valid/ready, job mask, rows, cols)
//   done              one-cycle pulse at batch end
//   err_timeout       sticky: engine stalled in RUN for TIMEOUT cycles
//   sat_flag          sticky: some written result was clipped
//   mv_*              engine control, vector-load and result interface
//   vec_rd_*          vector SRAM read port (1-cycle read latency)
//   res_wr_*          result buffer write port (combinational from result strobe)
module matvec_scheduler #(
  parameter int MAX_ROWS  = 64,
  parameter int MAX_COLS  = 64,
  parameter int BANDWIDTH = 16,
  parameter int NUM_JOBS  = 4,
  parameter int TIMEOUT   = 4096,
  parameter int DATA_W    = 16,
  localparam int R  = $clog2(MAX_ROWS),
  localparam int C  = $clog2(MAX_COLS),
  localparam int J  = $clog2(NUM_JOBS),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [NUM_JOBS-1:0]           cmd_job_mask,
  input  logic [R:0]                    cmd_rows,
  input  logic [C:0]                    cmd_cols,
  output logic                          done,
  output logic                          err_timeout,
  output logic                          sat_flag,
  output logic                          mv_start,
  output logic [R:0]                    mv_num_rows,
  output logic [C:0]                    mv_num_cols,
  output logic [J-1:0]                  mv_job,
  output logic                          mv_vec_we,
  output logic [C-1:0]                  mv_vec_base,
  output logic [DATA_W*BANDWIDTH-1:0]   mv_vec_data,
  input  logic                          mv_busy,
  input  logic signed [31:0]            mv_result,
  input  logic                          mv_result_valid,
  output logic                          vec_rd_en,
  output logic [C-1:0]                  vec_rd_addr,
  input  logic [DATA_W*BANDWIDTH-1:0]   vec_rd_data,
  output logic                          res_wr_en,
  output logic [J+R-1:0]                res_wr_addr,
  output logic [DATA_W-1:0]             res_wr_data
);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_PICK  = 6'b000010,
    S_START = 6'b000100,
    S_VLOAD = 6'b001000,
    S_RUN   = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  localparam logic signed [31:0] SAT_MAX  = (32'sd1 <<< (DATA_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN  = -(32'sd1 <<< (DATA_W - 1));
  localparam logic [C:0]         BW_STEP  = (C + 1)'(BANDWIDTH);
  localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT - 1);

  function automatic logic [DATA_W-1:0] sat_word(input logic signed [31:0] x);
    if (x > SAT_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x < SAT_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                  return x[DATA_W-1:0];
  endfunction

  function automatic logic sat_hit(input logic signed [31:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  state_t              state, state_nx;
  logic [NUM_JOBS-1:0] mask_q;
  logic [R:0]          rows_q;
  logic [C:0]          cols_q;
  logic [J-1:0]        job_q;
  logic [C:0]          rd_addr_q;   // next chunk base to read; one wider so it can pass cols
  logic [R:0]          row_q;
  logic [TW-1:0]       tmo_q;
  logic                err_q;
  logic                sat_q;
  logic                vld_p1;
  logic [C-1:0]        base_p1;

  logic                rd_more;
  logic                row_open;
  logic                wr_fire;
  logic                run_exit;
  logic                tmo_hit;
  logic [J-1:0]        pick_idx;

  assign rd_more  = (rd_addr_q < cols_q);
  assign row_open = (row_q < rows_q);
  assign wr_fire  = (state == S_RUN) && mv_result_valid && row_open;
  assign run_exit = (state == S_RUN) && !row_open && !mv_busy;
  assign tmo_hit  = (state == S_RUN) && !mv_result_valid && (tmo_q == TMO_LAST);

  // Lowest set bit wins, so jobs run in ascending index order.
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_JOBS - 1; i >= 0; i--) begin
      if (mask_q[i]) pick_idx = J'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nx = S_PICK;
      S_PICK:  state_nx = (mask_q == '0) ? S_DONE : S_START;
      S_START: state_nx = S_VLOAD;
      // Leave once the write for the final chunk is on the bus.
      S_VLOAD: if (vld_p1 && !rd_more) state_nx = S_RUN;
      S_RUN: begin
        if (run_exit)     state_nx = S_PICK;
        else if (tmo_hit) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign mv_start  = (state == S_START);
  assign vec_rd_en = (state == S_VLOAD) && rd_more;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      job_q     <= '0;
      rd_addr_q <= '0;
      row_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      sat_q     <= 1'b0;
      vld_p1    <= 1'b0;
      base_p1   <= '0;
    end else begin
      // Stage p1: SRAM data returns one cycle after the read, so the
      // engine write strobe and base address follow the read by one cycle.
      vld_p1  <= vec_rd_en;
      base_p1 <= rd_addr_q[C-1:0];
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            mask_q <= cmd_job_mask;
            rows_q <= cmd_rows;
            cols_q <= cmd_cols;
            err_q  <= 1'b0;
            sat_q  <= 1'b0;
          end
        end
        S_PICK: begin
          if (mask_q != '0) begin
            job_q  <= pick_idx;
            mask_q <= mask_q & (mask_q - NUM_JOBS'(1));
          end
        end
        S_START: begin
          rd_addr_q <= '0;
          row_q     <= '0;
          tmo_q     <= '0;
        end
        S_VLOAD: begin
          if (rd_more) rd_addr_q <= rd_addr_q + BW_STEP;
        end
        S_RUN: begin
          if (wr_fire) begin
            row_q <= row_q + (R + 1)'(1);
            if (sat_hit(mv_result)) sat_q <= 1'b1;
          end
          if (mv_result_valid)  tmo_q <= '0;
          else if (!tmo_hit)    tmo_q <= tmo_q + TW'(1);
          // A stalled engine abandons the rest of the batch.
          if (tmo_hit && !run_exit) begin
            err_q  <= 1'b1;
            mask_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mv_num_rows = rows_q;
  assign mv_num_cols = cols_q;
  assign mv_job      = job_q;
  assign mv_vec_we   = vld_p1;
  assign mv_vec_base = base_p1;
  assign mv_vec_data = vec_rd_data;
  assign vec_rd_addr = rd_addr_q[C-1:0];
  assign err_timeout = err_q;
  assign sat_flag    = sat_q;

  assign res_wr_en   = wr_fire;
  assign res_wr_addr = {job_q, row_q[R-1:0]};
  assign res_wr_data = wr_fire ? sat_word(mv_result) : '0;

endmodule

// File: doc/matvec_scheduler.md
# matvec_scheduler

Sequences a batch of up to NUM_JOBS matrix-vector jobs (e.g. the four LSTM gates i/f/g/o) through the single shared `matvec_multiplier` engine. For each job it:
- starts the engine;
- streams the input vector from vector SRAM in BANDWIDTH-wide chunks;
- tells the matrix loader which weight bank to serve;
- collects one result per row, saturating Q20.12 to Q4.12, into the gate result buffer.

It sits between the LSTM cell controller (command side) and the engine / vector SRAM / result buffer.

## Interface
- MAX_ROWS, 64, max rows per job
- MAX_COLS, 64, max columns per job; vector SRAM depth
- BANDWIDTH, 16, vector words per chunk
- NUM_JOBS, 4, jobs per batch; J = $clog2(NUM_JOBS)
- TIMEOUT, 4096, max cycles in RUN without a `mv_result_valid`

Ports (R = $clog2(MAX_ROWS), C = $clog2(MAX_COLS)):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  batch request
- cmd_ready  out  1  high only in IDLE
- cmd_job_mask  in  NUM_JOBS  jobs to run; bit j = job j
- cmd_rows  in  R+1  rows per job, 1..MAX_ROWS
- cmd_cols  in  C+1  cols per job, 1..MAX_COLS
- done  out  1  one-cycle pulse at batch end
- err_timeout  out  1  sticky; cleared on command accept
- sat_flag  out  1  sticky: any result saturated; cleared on command accept
- mv_start  out  1  engine start pulse
- mv_num_rows  out  R+1  registered cmd_rows
- mv_num_cols  out  C+1  registered cmd_cols
- mv_job  out  J  current job index, for matrix loader bank select
- mv_vec_we  out  1  engine vector_write_enable
- mv_vec_base  out  C  engine vector_base_addr
- mv_vec_data  out  16×BANDWIDTH  Q4.12 chunk; passthrough of vec_rd_data
- mv_busy  in  1  engine busy
- mv_result  in  32  engine result, signed Q20.12
- mv_result_valid  in  1  engine result strobe
- vec_rd_en  out  1  vector SRAM read
- vec_rd_addr  out  C  chunk base address
- vec_rd_data  in  16×BANDWIDTH  read data, 1-cycle latency
- res_wr_en  out  1  result buffer write
- res_wr_addr  out  J+R  {job, row}
- res_wr_data  out  16  saturated Q4.12

## Operation
- **States:** IDLE, PICK, START, VLOAD, RUN, DONE. One-hot encoded.
- **IDLE:** `cmd_ready` = 1.
  - On `cmd_valid`: latch mask, rows and cols; clear `err_timeout` and `sat_flag`; go to PICK.
  - An all-zero mask takes PICK → DONE directly.
- **PICK:** select the lowest set bit of the remaining mask into `mv_job` and clear that bit.
  - Mask empty → DONE; otherwise → START.
- **START:** `mv_start` = 1 for exactly one cycle; reset chunk counter k, row counter and timeout counter; → VLOAD.
- **VLOAD:**
  - NCH = ceil(cols/BANDWIDTH). For k = 0..NCH-1, issue `vec_rd_en` with `vec_rd_addr` = k·BANDWIDTH.
  - One cycle later, assert `mv_vec_we` with `mv_vec_base` = k·BANDWIDTH and `mv_vec_data` = `vec_rd_data`.
  - After the last `mv_vec_we` cycle → RUN. Exactly NCH write pulses per job; no gaps.
- **RUN:** each `mv_result_valid` produces a write the same cycle:
  - `res_wr_en` = 1, `res_wr_addr` = {mv_job, row}; row increments.
  - Saturation: if `mv_result` > 32767 → 0x7FFF, else if < -32768 → 0x8000 (sets `sat_flag`); otherwise the low 16 bits.
  - Exit to PICK when row == rows and `mv_busy` == 0.
  - Any `mv_result_valid` after row == rows is ignored (no write).
- **Timeout:** counter resets on each `mv_result_valid`. When it reaches TIMEOUT: set `err_timeout`, discard the remaining mask, → DONE.
- **DONE:** `done` = 1 for one cycle; → IDLE.
- `cmd_valid` outside IDLE is ignored. Rows and cols stay constant across all jobs of a batch.

## Timing
- **Reset (async, any state):**
  - State → IDLE.
  - All outputs 0 except `cmd_ready` = 1; `mv_num_rows` and `mv_num_cols` = 0.
  - Mask and counters cleared.
- **Batch start:** accept at cycle 0, PICK at cycle 1, `mv_start` at cycle 2.
- **Vector load:** first `vec_rd_en` at cycle 3, first `mv_vec_we` at cycle 4, last `mv_vec_we` at cycle 3+NCH; RUN begins cycle 4+NCH.
- **Result writes:** `res_wr_*` is combinational from `mv_result_valid` (zero latency); the result buffer captures on the same edge.
- **Between jobs:** RUN exit → PICK → START costs 2 cycles.
- **End of batch:** `done` follows the final PICK by 1 cycle; `cmd_ready` rises the cycle after `done`.
- `mv_num_rows` and `mv_num_cols` are stable from the cycle after accept until the next accept.

## Test plan
- **Single job:** mask=0001, rows=4, cols=20, engine model returns 4 results → 2 chunk writes at bases 0 and 16; 4 result writes to addrs 0..3; `done` 1 pulse; `cmd_ready` back high.
- **Four gates:** mask=1111, rows=8, cols=64 → jobs run in order 0,1,2,3; 4 `mv_vec_we` pulses per job; 32 writes at {j,0..7}; exactly 4 `mv_start` pulses.
- **Sparse mask and saturation:** mask=1010; results 0x00012000 and 0xFFFE0000 → jobs 1 then 3; data 0x7FFF and 0x8000; `sat_flag`=1. In-range 0x00000800 → 0x0800 with `sat_flag` unchanged.
- **Timeout:** engine never asserts `mv_result_valid` → `err_timeout`=1 after TIMEOUT RUN cycles; `done` pulse; remaining jobs not started.
- **Reset mid-RUN:** assert rst_n=0 during job 2 → outputs reset immediately; next command runs cleanly from job 0.
- **Edges:** cols=1 (NCH=1) and cols=64 (NCH=4); `cmd_valid` held during busy → no re-accept; mask=0000 → `done` at cycle 2 with no `mv_start`.
